// File: rtl/regfile_sequencer_pkg.sv
// Shared encodings for the register-file sequencer: ALU ops and one-hot FSM states.
package regfile_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_LI  = 2'b11
  } op_e;

  // One-hot so illegal states are trivially detectable.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_READ  = 4'b0010,
    ST_EXEC  = 4'b0100,
    ST_WRITE = 4'b1000
  } state_e;

endpackage

// File: rtl/regfile_sequencer_if.sv
// Instruction handshake plus register-file pins of the sequencer.
interface regfile_sequencer_if #(
  parameter int WIDTH         = 4,
  parameter int ADDRESS_WIDTH = 2
);
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               in_op;
  logic [ADDRESS_WIDTH-1:0] in_src0;
  logic [ADDRESS_WIDTH-1:0] in_src1;
  logic [ADDRESS_WIDTH-1:0] in_dst;
  logic [WIDTH-1:0]         in_imm;
  logic [ADDRESS_WIDTH-1:0] rf_a0;
  logic [ADDRESS_WIDTH-1:0] rf_a1;
  logic [ADDRESS_WIDTH-1:0] rf_a2;
  logic                     rf_we;
  logic [WIDTH-1:0]         rf_wd;
  logic [WIDTH-1:0]         rf_rd0;
  logic [WIDTH-1:0]         rf_rd1;
  logic                     done;
  logic [WIDTH-1:0]         result;

  // Sequencer side.
  modport master (
    input  in_valid, in_op, in_src0, in_src1, in_dst, in_imm, rf_rd0, rf_rd1,
    output in_ready, rf_a0, rf_a1, rf_a2, rf_we, rf_wd, done, result
  );

  // Instruction source and register file side.
  modport slave (
    output in_valid, in_op, in_src0, in_src1, in_dst, in_imm, rf_rd0, rf_rd1,
    input  in_ready, rf_a0, rf_a1, rf_a2, rf_we, rf_wd, done, result
  );
endinterface

// File: rtl/regfile_seq_alu.sv
// Combinational ALU: ADD/SUB/AND on captured operands, LI passes the immediate.
module regfile_seq_alu
  import regfile_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] op0,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] value
);

  // Select the result; all arithmetic wraps modulo 2^WIDTH.
  always_comb begin
    value = '0;
    unique case (op)
      OP_ADD:  value = op0 + op1;
      OP_SUB:  value = op0 - op1;
      OP_AND:  value = op0 & op1;
      OP_LI:   value = imm;
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Four-cycle read/execute/write-back sequencer driving a 2R1W register file.
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int ADDRESS_WIDTH = 2
) (
  input logic                 clock,
  input logic                 reset,
  regfile_sequencer_if.master bus
);

  state_e                   r_state;
  state_e                   w_state_next;
  op_e                      r_op;
  logic [ADDRESS_WIDTH-1:0] r_dst;
  logic [WIDTH-1:0]         r_imm;
  logic [ADDRESS_WIDTH-1:0] r_a0;
  logic [ADDRESS_WIDTH-1:0] r_a1;
  logic [ADDRESS_WIDTH-1:0] r_a2;
  logic                     r_we;
  logic [WIDTH-1:0]         r_wd;
  logic [WIDTH-1:0]         r_op0;
  logic [WIDTH-1:0]         r_op1;
  logic [WIDTH-1:0]         r_result;
  logic [WIDTH-1:0]         w_alu;

  regfile_seq_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op   (r_op),
    .op0  (r_op0),
    .op1  (r_op1),
    .imm  (r_imm),
    .value(w_alu)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state: fixed READ -> EXEC -> WRITE walk once an instruction is taken.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (bus.in_valid) w_state_next = ST_READ;
      ST_READ:  w_state_next = ST_EXEC;
      ST_EXEC:  w_state_next = ST_WRITE;
      ST_WRITE: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Datapath registers: latch instruction, capture operands, load write-back.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op     <= OP_ADD;
      r_dst    <= '0;
      r_imm    <= '0;
      r_a0     <= '0;
      r_a1     <= '0;
      r_a2     <= '0;
      r_we     <= 1'b0;
      r_wd     <= '0;
      r_op0    <= '0;
      r_op1    <= '0;
      r_result <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_op  <= op_e'(bus.in_op);
            r_dst <= bus.in_dst;
            r_imm <= bus.in_imm;
            r_a0  <= bus.in_src0;
            r_a1  <= bus.in_src1;
          end
        end
        ST_READ: begin
          r_op0 <= bus.rf_rd0;
          r_op1 <= bus.rf_rd1;
        end
        ST_EXEC: begin
          r_result <= w_alu;
          r_wd     <= w_alu;
          r_a2     <= r_dst;
          // Register 0 is hard-wired zero, so skip the write entirely.
          r_we     <= (r_dst != '0);
        end
        ST_WRITE: r_we <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready = (r_state == ST_IDLE);
  assign bus.done     = (r_state == ST_WRITE);
  assign bus.rf_a0    = r_a0;
  assign bus.rf_a1    = r_a1;
  assign bus.rf_a2    = r_a2;
  assign bus.rf_we    = r_we;
  assign bus.rf_wd    = r_wd;
  assign bus.result   = r_result;

  a_state_onehot: assert property (@(posedge clock) disable iff (reset) $onehot(r_state));
  a_we_in_write:  assert property (@(posedge clock) disable iff (reset)
                                   r_we |-> (r_state == ST_WRITE));

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench: sequencer plus a behavioural 2R1W register file (r0 reads zero).
module tb_regfile_sequencer;
  import regfile_sequencer_pkg::*;

  localparam int W  = 4;
  localparam int AW = 2;

  logic clock = 1'b0;
  logic reset;

  regfile_sequencer_if #(.WIDTH(W), .ADDRESS_WIDTH(AW)) bus ();

  regfile_sequencer #(
    .WIDTH        (W),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Register file model.
  logic [W-1:0] rf_mem [4];
  assign bus.rf_rd0 = (bus.rf_a0 == '0) ? '0 : rf_mem[bus.rf_a0];
  assign bus.rf_rd1 = (bus.rf_a1 == '0) ? '0 : rf_mem[bus.rf_a1];
  always @(posedge clock) begin
    if (bus.rf_we && bus.rf_a2 != '0) rf_mem[bus.rf_a2] <= bus.rf_wd;
  end

  // Count write-enable cycles seen at clock edges.
  int we_cnt = 0;
  always @(posedge clock) begin
    if (bus.rf_we) we_cnt <= we_cnt + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one instruction from IDLE and check every cycle through write-back.
  task automatic run_instr(input logic [1:0] op, input logic [1:0] s0, input logic [1:0] s1,
                           input logic [1:0] d, input logic [3:0] imm,
                           input logic [3:0] exp_res, input string tag);
    int we0;
    @(negedge clock);
    check_eq({tag, " in_ready"}, bus.in_ready, 1);
    bus.in_op    = op;
    bus.in_src0  = s0;
    bus.in_src1  = s1;
    bus.in_dst   = d;
    bus.in_imm   = imm;
    bus.in_valid = 1'b1;
    we0 = we_cnt;
    @(posedge clock);  // E0
    #1 bus.in_valid = 1'b0;
    check_eq({tag, " rf_a0"}, bus.rf_a0, s0);
    check_eq({tag, " rf_a1"}, bus.rf_a1, s1);
    check_eq({tag, " in_ready busy"}, bus.in_ready, 0);
    @(posedge clock);  // E1
    #1 check_eq({tag, " done early"}, bus.done, 0);
    @(posedge clock);  // E2
    #1;
    check_eq({tag, " done"}, bus.done, 1);
    check_eq({tag, " result"}, bus.result, exp_res);
    check_eq({tag, " rf_we"}, bus.rf_we, (d != 2'd0));
    check_eq({tag, " rf_a2"}, bus.rf_a2, d);
    check_eq({tag, " rf_wd"}, bus.rf_wd, exp_res);
    @(posedge clock);  // E3
    #1;
    check_eq({tag, " done end"}, bus.done, 0);
    check_eq({tag, " rf_we end"}, bus.rf_we, 0);
    check_eq({tag, " we pulses"}, we_cnt - we0, (d != 2'd0) ? 1 : 0);
    check_eq({tag, " in_ready back"}, bus.in_ready, 1);
    if (d != 2'd0) check_eq({tag, " rf content"}, rf_mem[d], exp_res);
  endtask

  initial begin
    logic [11:0] acc_mask;
    int          we0;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_op    = '0;
    bus.in_src0  = '0;
    bus.in_src1  = '0;
    bus.in_dst   = '0;
    bus.in_imm   = '0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst in_ready", bus.in_ready, 1);
    check_eq("rst rf_we", bus.rf_we, 0);
    check_eq("rst done", bus.done, 0);
    check_eq("rst result", bus.result, 0);
    check_eq("rst rf_a0", bus.rf_a0, 0);
    check_eq("rst rf_a2", bus.rf_a2, 0);
    check_eq("rst rf_wd", bus.rf_wd, 0);
    @(negedge clock);
    reset = 1'b0;

    run_instr(OP_LI,  2'd0, 2'd0, 2'd1, 4'd9,  4'd9,  "li r1");
    run_instr(OP_LI,  2'd0, 2'd0, 2'd2, 4'd12, 4'd12, "li r2");
    run_instr(OP_ADD, 2'd1, 2'd2, 2'd3, 4'd0,  4'd5,  "add r3");
    run_instr(OP_AND, 2'd3, 2'd1, 2'd3, 4'd0,  4'd1,  "and r3");
    run_instr(OP_SUB, 2'd1, 2'd2, 2'd3, 4'd0,  4'd13, "sub r3");
    run_instr(OP_LI,  2'd0, 2'd0, 2'd0, 4'd7,  4'd7,  "li r0");
    run_instr(OP_ADD, 2'd0, 2'd0, 2'd1, 4'd15, 4'd0,  "add r0r0");

    // Valid held high with fields changing every cycle: only every 4th is taken.
    acc_mask = '0;
    we0      = we_cnt;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      bus.in_op    = OP_LI;
      bus.in_dst   = 2'((k % 3) + 1);
      bus.in_imm   = 4'(k + 1);
      bus.in_src0  = 2'(k);
      bus.in_src1  = 2'(k + 1);
      bus.in_valid = 1'b1;
      acc_mask[k]  = bus.in_ready;
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    check_eq("stream accepts", acc_mask, 12'b0001_0001_0001);
    check_eq("stream we pulses", we_cnt - we0, 3);
    check_eq("stream r1", rf_mem[1], 1);
    check_eq("stream r2", rf_mem[2], 5);
    check_eq("stream r3", rf_mem[3], 9);
    check_eq("stream result", bus.result, 9);

    // Reset during EXEC of ADD r3,r1,r2: no write may reach r3.
    @(negedge clock);
    we0          = we_cnt;
    bus.in_op    = OP_ADD;
    bus.in_src0  = 2'd1;
    bus.in_src1  = 2'd2;
    bus.in_dst   = 2'd3;
    bus.in_imm   = 4'd0;
    bus.in_valid = 1'b1;
    @(posedge clock);  // E0
    #1 bus.in_valid = 1'b0;
    @(posedge clock);  // E1, now in EXEC
    #1 reset = 1'b1;
    #1;
    check_eq("midrst in_ready", bus.in_ready, 1);
    check_eq("midrst rf_we", bus.rf_we, 0);
    check_eq("midrst done", bus.done, 0);
    check_eq("midrst result", bus.result, 0);
    check_eq("midrst rf_a0", bus.rf_a0, 0);
    check_eq("midrst rf_a1", bus.rf_a1, 0);
    check_eq("midrst rf_a2", bus.rf_a2, 0);
    check_eq("midrst rf_wd", bus.rf_wd, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_eq("postrst in_ready", bus.in_ready, 1);
    check_eq("postrst done", bus.done, 0);
    check_eq("postrst we pulses", we_cnt - we0, 0);
    check_eq("postrst r3 kept", rf_mem[3], 9);

    // Sequencer still works after reset.
    run_instr(OP_ADD, 2'd1, 2'd2, 2'd3, 4'd0, 4'd6, "add after rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
